// File: rtl/vga_pic_gen.sv
// vga_pic_gen: registered RGB565 test-pattern source (bars, checker, bouncing box, white)
// for the VGA timing stage; one-cycle latency from pixel coordinate to rgb.
module vga_pic_gen #(
  parameter int H_VALID  = 640,
  parameter int V_VALID  = 480,
  parameter int BOX_SIZE = 64,
  parameter int STEP     = 2,
  parameter int CHK_LOG2 = 5
) (
  input  logic        i_vga_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_pix_x,
  input  logic [9:0]  i_pix_y,
  input  logic        i_pix_valid,
  input  logic        i_frame_start,
  input  logic [1:0]  i_mode_sel,
  output logic [15:0] o_rgb
);
  localparam logic [10:0] X_MAX = 11'(H_VALID - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_VALID - BOX_SIZE);
  localparam logic [10:0] STP   = 11'(STEP);
  localparam logic [10:0] BSZ   = 11'(BOX_SIZE);
  localparam logic [15:0] BAR_COL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [15:0] BOX_COL [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0};

  logic [1:0]  r_mode;
  logic [9:0]  r_box_x, r_box_y;
  logic        r_dir_x, r_dir_y;
  logic [1:0]  r_col_idx;
  logic [15:0] r_rgb;

  logic [10:0] w_px, w_py, w_bx, w_by, w_nx, w_ny;
  logic        w_hit_x, w_hit_y, w_in_box, w_in_range;
  logic [2:0]  w_bar;
  logic [9:0]  w_box_x_nxt, w_box_y_nxt;
  logic [15:0] w_pix;

  assign w_px = {1'b0, i_pix_x};
  assign w_py = {1'b0, i_pix_y};
  assign w_bx = {1'b0, r_box_x};
  assign w_by = {1'b0, r_box_y};
  assign w_nx = w_bx + STP;
  assign w_ny = w_by + STP;

  // r_dir_* = 1 means moving toward 0; 11-bit compares avoid wrap at the far edge
  assign w_hit_x = r_dir_x ? (w_bx < STP) : (w_nx > X_MAX);
  assign w_hit_y = r_dir_y ? (w_by < STP) : (w_ny > Y_MAX);
  assign w_box_x_nxt = w_hit_x ? (r_dir_x ? '0 : X_MAX[9:0])
                               : (r_dir_x ? 10'(w_bx - STP) : w_nx[9:0]);
  assign w_box_y_nxt = w_hit_y ? (r_dir_y ? '0 : Y_MAX[9:0])
                               : (r_dir_y ? 10'(w_by - STP) : w_ny[9:0]);

  assign w_bar      = 3'(i_pix_x / 10'(H_VALID / 8));
  assign w_in_range = (w_px < 11'(H_VALID)) && (w_py < 11'(V_VALID));
  assign w_in_box   = (w_px >= w_bx) && (w_px < w_bx + BSZ) &&
                      (w_py >= w_by) && (w_py < w_by + BSZ);

  assign w_pix = (!i_pix_valid || !w_in_range) ? 16'h0000 :
                 (r_mode == 2'd0) ? BAR_COL[w_bar] :
                 (r_mode == 2'd1) ? ((i_pix_x[CHK_LOG2] ^ i_pix_y[CHK_LOG2]) ? 16'hFFFF : 16'h0000) :
                 (r_mode == 2'd2) ? (w_in_box ? BOX_COL[r_col_idx] : 16'h0010) :
                 16'hFFFF;

  always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb     <= '0;
      r_mode    <= '0;
      r_box_x   <= '0;
      r_box_y   <= '0;
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
      r_col_idx <= '0;
    end else begin
      r_rgb <= w_pix;
      if (i_frame_start) begin
        r_mode    <= i_mode_sel;
        r_box_x   <= w_box_x_nxt;
        r_box_y   <= w_box_y_nxt;
        r_dir_x   <= r_dir_x ^ w_hit_x;
        r_dir_y   <= r_dir_y ^ w_hit_y;
        r_col_idx <= r_col_idx + {1'b0, w_hit_x | w_hit_y};
      end
    end
  end

  assign o_rgb = r_rgb;
endmodule
